// File: rtl/sum_pkg.sv
// Shared types and sizing helpers for the sum_pair_bist operand sweeper.
package sum_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned DefaultW = 2;

  function automatic int unsigned npairs(input int unsigned w);
    return 2 ** (2 * w);
  endfunction

  function automatic int unsigned res_width(input int unsigned w);
    return w + 1;
  endfunction

  // Wide enough to hold npairs(w) so an all-fail sweep never wraps.
  function automatic int unsigned err_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

  localparam int unsigned NPAIRS = npairs(DefaultW);
  localparam int unsigned RES_W  = res_width(DefaultW);
  localparam int unsigned ERR_W  = err_width(DefaultW);

endpackage

// File: rtl/sum_pair_counter.sv
// 2W-bit operand-pair down-counter; upper half is ft, lower half is st.
module sum_pair_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_all_ones,
  input  logic         dec,
  output logic [W-1:0] ft,
  output logic [W-1:0] st,
  output logic         zero
);

  localparam logic [2*W-1:0] One = {{(2*W-1){1'b0}}, 1'b1};

  logic [2*W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_all_ones) begin
      cnt_q <= '1;
    end else if (dec) begin
      cnt_q <= cnt_q - One;
    end
  end

  assign ft   = cnt_q[2*W-1:W];
  assign st   = cnt_q[W-1:0];
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sum_pair_bist.sv
// Exhaustive operand sweeper and checker for a W-bit adder: drives every ft/st
// pair, compares the sampled res with a golden sum and records the first failure.
module sum_pair_bist
  import sum_pkg::*;
#(
  parameter int unsigned W      = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   ft,
  output logic [W-1:0]   st,
  input  logic [W:0]     res,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_count,
  output logic [W-1:0]   fail_ft,
  output logic [W-1:0]   fail_st,
  output logic [W:0]     fail_res
);

  localparam int unsigned ResW = res_width(W);
  localparam int unsigned ErrW = err_width(W);
  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0] CntOne     = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [ErrW-1:0] ErrOne     = {{(ErrW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic [W-1:0]      fail_ft_q, fail_ft_d;
  logic [W-1:0]      fail_st_q, fail_st_d;
  logic [ResW-1:0]   fail_res_q, fail_res_d;
  logic [ResW-1:0]   golden;
  logic              pair_load, pair_dec, pair_zero;

  sum_pair_counter #(
    .W (W)
  ) u_pair_counter (
    .clk           (clk),
    .rst           (rst),
    .load_all_ones (pair_load),
    .dec           (pair_dec),
    .ft            (ft),
    .st            (st),
    .zero          (pair_zero)
  );

  assign golden = {1'b0, ft} + {1'b0, st};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fail_ft_d  = fail_ft_q;
    fail_st_d  = fail_st_q;
    fail_res_d = fail_res_q;
    pair_load  = 1'b0;
    pair_dec   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_APPLY;
          cnt_d      = SettleLoad;
          err_d      = '0;
          fail_ft_d  = '0;
          fail_st_d  = '0;
          fail_res_d = '0;
          pair_load  = 1'b1;
        end
      end
      S_APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntOne;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (res != golden) begin
          err_d = err_q + ErrOne;
          if (err_q == '0) begin
            fail_ft_d  = ft;
            fail_st_d  = st;
            fail_res_d = res;
          end
        end
        if (pair_zero) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_APPLY;
          cnt_d    = SettleLoad;
          pair_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_q      <= '0;
      fail_ft_q  <= '0;
      fail_st_q  <= '0;
      fail_res_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      fail_ft_q  <= fail_ft_d;
      fail_st_q  <= fail_st_d;
      fail_res_q <= fail_res_d;
    end
  end

  always_comb begin
    busy = (state_q == S_APPLY) || (state_q == S_CHECK);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (err_q == '0);
  end

  assign err_count = err_q;
  assign fail_ft   = fail_ft_q;
  assign fail_st   = fail_st_q;
  assign fail_res  = fail_res_q;

endmodule

// File: tb/tb_sum_pair_bist.sv
// Directed bench for sum_pair_bist: golden and faulty adder models, restart,
// mid-sweep start/reset, and a SETTLE=3 instance.
module tb_sum_pair_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] ft_a, st_a, ft_b, st_b;
  logic [2:0] res_a, res_b, sum_a;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [4:0] err_a, err_b;
  logic [1:0] fail_ft_a, fail_st_a, fail_ft_b, fail_st_b;
  logic [2:0] fail_res_a, fail_res_b;
  int         fault = 0;  // 0 golden, 1 res stuck at 000, 2 res bit0 stuck at 1
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  assign sum_a = {1'b0, ft_a} + {1'b0, st_a};
  assign res_a = (fault == 1) ? 3'b000 : (fault == 2) ? (sum_a | 3'b001) : sum_a;
  assign res_b = {1'b0, ft_b} + {1'b0, st_b};

  sum_pair_bist #(.W(2), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .ft(ft_a), .st(st_a), .res(res_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .fail_ft(fail_ft_a), .fail_st(fail_st_a), .fail_res(fail_res_a)
  );

  sum_pair_bist #(.W(2), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ft(ft_b), .st(st_b), .res(res_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_ft(fail_ft_b), .fail_st(fail_st_b), .fail_res(fail_res_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the start edge, i.e. when busy should first be high.
  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cycles);
    cycles = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy_a, done_a, pass_a, err_a, ft_a, st_a, fail_ft_a, fail_st_a, fail_res_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got busy=%b done=%b pass=%b err=%0d ft=%0d st=%0d expected all 0",
               busy_a, done_a, pass_a, err_a, ft_a, st_a);
    end
    n_cmp++;
    if ({busy_b, done_b, pass_b, err_b, ft_b, st_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got busy=%b done=%b err=%0d expected all 0", busy_b, done_b, err_b);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_golden_order();
    fault = 0;
    pulse_start(1'b0);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (ft_a !== 2'(3 - k / 4) || st_a !== 2'(3 - k % 4) || busy_a !== 1'b1) begin
        n_bad++;
        $display("FAIL order[%0d]: got ft=%0d st=%0d busy=%b expected ft=%0d st=%0d busy=1",
                 k, ft_a, st_a, busy_a, 3 - k / 4, 3 - k % 4);
      end
      step();
      step();
    end
    n_cmp++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== 1'b1 || err_a !== 5'd0) begin
      n_bad++;
      $display("FAIL golden_end: got done=%b busy=%b pass=%b err=%0d expected 1 0 1 0",
               done_a, busy_a, pass_a, err_a);
    end
    n_cmp++;
    if (ft_a !== 2'd0 || st_a !== 2'd0) begin
      n_bad++;
      $display("FAIL golden_hold: got ft=%0d st=%0d expected 0 0", ft_a, st_a);
    end
  endtask

  task automatic test_fault(input int mode, input int exp_err, input logic [2:0] exp_res);
    int cyc;
    fault = mode;
    pulse_start(1'b0);
    wait_done(1'b0, cyc);
    n_cmp++;
    if (cyc !== 32) begin
      n_bad++;
      $display("FAIL fault%0d_cycles: got %0d expected 32", mode, cyc);
    end
    n_cmp++;
    if (err_a !== 5'(exp_err) || pass_a !== 1'b0) begin
      n_bad++;
      $display("FAIL fault%0d_count: got err=%0d pass=%b expected err=%0d pass=0",
               mode, err_a, pass_a, exp_err);
    end
    n_cmp++;
    if (fail_ft_a !== 2'd3 || fail_st_a !== 2'd3 || fail_res_a !== exp_res) begin
      n_bad++;
      $display("FAIL fault%0d_first: got ft=%0d st=%0d res=%b expected 3 3 %b",
               mode, fail_ft_a, fail_st_a, fail_res_a, exp_res);
    end
  endtask

  task automatic test_restart_clean();
    int cyc;
    fault = 0;
    pulse_start(1'b0);
    n_cmp++;
    if (err_a !== 5'd0 || {fail_ft_a, fail_st_a, fail_res_a} !== 7'd0 || busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_clear: got err=%0d fail=%0d/%0d/%0d busy=%b expected 0 0/0/0 1",
               err_a, fail_ft_a, fail_st_a, fail_res_a, busy_a);
    end
    wait_done(1'b0, cyc);
    n_cmp++;
    if (cyc !== 32 || pass_a !== 1'b1 || {fail_ft_a, fail_st_a, fail_res_a} !== 7'd0) begin
      n_bad++;
      $display("FAIL restart_end: got cycles=%0d pass=%b expected 32 1", cyc, pass_a);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc = 0;
    fault = 0;
    pulse_start(1'b0);
    while (done_a !== 1'b1 && cyc < 200) begin
      start_a = (cyc == 10);
      step();
      cyc++;
    end
    start_a = 1'b0;
    n_cmp++;
    if (cyc !== 32 || err_a !== 5'd0 || pass_a !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start: got cycles=%0d err=%0d pass=%b expected 32 0 1",
               cyc, err_a, pass_a);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    fault = 1;
    pulse_start(1'b0);
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy_a, done_a, pass_a, err_a, ft_a, st_a, fail_ft_a, fail_st_a, fail_res_a} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got busy=%b done=%b err=%0d ft=%0d st=%0d fail_ft=%0d expected 0",
               busy_a, done_a, err_a, ft_a, st_a, fail_ft_a);
    end
    fault = 0;
    step();
    pulse_start(1'b0);
    wait_done(1'b0, cyc);
    n_cmp++;
    if (cyc !== 32 || pass_a !== 1'b1 || err_a !== 5'd0) begin
      n_bad++;
      $display("FAIL post_reset_sweep: got cycles=%0d pass=%b err=%0d expected 32 1 0",
               cyc, pass_a, err_a);
    end
  endtask

  task automatic test_start_held();
    int cyc;
    fault = 0;
    start_a = 1'b1;
    step();
    wait_done(1'b0, cyc);
    n_cmp++;
    if (cyc !== 32) begin
      n_bad++;
      $display("FAIL held_cycles: got %0d expected 32", cyc);
    end
    step();
    n_cmp++;
    if (busy_a !== 1'b1 || done_a !== 1'b0 || ft_a !== 2'd3 || st_a !== 2'd3) begin
      n_bad++;
      $display("FAIL held_rearm: got busy=%b done=%b ft=%0d st=%0d expected 1 0 3 3",
               busy_a, done_a, ft_a, st_a);
    end
    start_a = 1'b0;
    wait_done(1'b0, cyc);
  endtask

  task automatic test_settle3();
    int cyc;
    pulse_start(1'b1);
    step();
    step();
    step();
    n_cmp++;
    if (ft_b !== 2'd3 || st_b !== 2'd3 || busy_b !== 1'b1) begin
      n_bad++;
      $display("FAIL settle3_hold: got ft=%0d st=%0d busy=%b expected 3 3 1", ft_b, st_b, busy_b);
    end
    wait_done(1'b1, cyc);
    cyc += 3;
    n_cmp++;
    if (cyc !== 64 || pass_b !== 1'b1 || err_b !== 5'd0) begin
      n_bad++;
      $display("FAIL settle3_end: got cycles=%0d pass=%b err=%0d expected 64 1 0",
               cyc, pass_b, err_b);
    end
  endtask

  initial begin
    test_reset();
    test_golden_order();
    test_start_while_busy();
    test_fault(1, 15, 3'b000);
    test_restart_clean();
    test_fault(2, 8, 3'b111);
    test_reset_mid_sweep();
    test_start_held();
    test_settle3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
